// File: rtl/avl_stream_reader_if.sv
// Avalon-style memory bus between an initiator and a word-addressed slave.
// Ports: master drives request side, slave drives ready/response side.
interface i_avl_bus;
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic        read;
    logic        write;
    logic [31:0] write_data;
    logic        begin_burst_transfer;
    logic [7:0]  burst_count;
    logic        request_ready;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        resp_ready;

    modport master (
        output address, byte_en, read, write, write_data,
        output begin_burst_transfer, burst_count, resp_ready,
        input  request_ready, read_data, read_data_valid
    );

    modport slave (
        input  address, byte_en, read, write, write_data,
        input  begin_burst_transfer, burst_count, resp_ready,
        output request_ready, read_data, read_data_valid
    );
endinterface

// File: rtl/avl_stream_reader.sv
// Reads word_count words from base_addr over avl_m0, streams them out.
// Ports: start/base_addr/word_count in, busy/done status, out_* stream.
module avl_stream_reader #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rest,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic [LEN_WIDTH-1:0] word_count,
    output logic                 busy,
    output logic                 done,
    i_avl_bus.master             avl_m0,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] issued;
    logic [LEN_WIDTH-1:0] popped;
    logic [31:0]          addr;
    logic [CW-1:0]        in_flight;
    logic [CW-1:0]        fifo_count;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [31:0]          mem [MAX_OUTSTANDING];
    logic                 req_acc;
    logic                 rsp_acc;
    logic                 pop;
    logic                 fifo_full;
    logic                 credit_ok;
    logic                 read_en;
    logic                 last_pop;
    logic                 accept_start;

    assign avl_m0.write                = 1'b0;
    assign avl_m0.write_data           = 32'd0;
    assign avl_m0.byte_en              = 4'hF;
    assign avl_m0.burst_count          = 8'd1;
    assign avl_m0.begin_burst_transfer = 1'b0;

    // Credits count both reads on the bus and words parked in the FIFO,
    // so a response can never find the FIFO full.
    assign fifo_full = fifo_count == CW'(MAX_OUTSTANDING);
    assign credit_ok = ({1'b0, in_flight} + {1'b0, fifo_count})
                       < (CW+1)'(MAX_OUTSTANDING);

    // Built from registers only: once raised it cannot fall before accept,
    // since neither the credit sum nor issued moves without an accept.
    assign read_en = (state == RUN) && (issued != len) && credit_ok;

    assign avl_m0.read       = read_en;
    assign avl_m0.address    = addr;
    assign avl_m0.resp_ready = !fifo_full;

    assign req_acc  = read_en && avl_m0.request_ready;
    assign rsp_acc  = avl_m0.read_data_valid && !fifo_full;
    assign pop      = out_valid && out_ready;
    assign last_pop = pop && (popped == len - LEN_WIDTH'(1));

    assign accept_start = (state == IDLE) && start;

    assign out_valid = fifo_count != '0;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (word_count == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (last_pop) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            len        <= '0;
            issued     <= '0;
            popped     <= '0;
            addr       <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (accept_start) begin
                len    <= word_count;
                addr   <= base_addr & 32'hFFFF_FFFC;
                issued <= '0;
                popped <= '0;
            end else begin
                if (req_acc) begin
                    addr   <= addr + 32'd4;
                    issued <= issued + LEN_WIDTH'(1);
                end
                if (pop) popped <= popped + LEN_WIDTH'(1);
            end
            in_flight  <= in_flight + CW'(req_acc) - CW'(rsp_acc);
            fifo_count <= fifo_count + CW'(rsp_acc) - CW'(pop);
            if (rsp_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_acc) mem[wr_ptr] <= avl_m0.read_data;
    end

endmodule

// File: tb/tb_avl_stream_reader.sv
// Scoreboard bench for avl_stream_reader with an in-order slave model.
// Slave returns ram[i]=i, i.e. data = byte address >> 2.
module tb_avl_stream_reader;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rest;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    i_avl_bus bus();

    avl_stream_reader #(
        .MAX_OUTSTANDING(MAXO),
        .LEN_WIDTH(16)
    ) dut (
        .clk(clk),
        .rest(rest),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .busy(busy),
        .done(done),
        .avl_m0(bus.master),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int rq_mode = 0;
    int dv_mode = 0;
    int or_mode = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] pend[$];

    int acc_total = 0;
    int rsp_total = 0;
    int pop_total = 0;
    int done_cnt = 0;
    int done_base = 0;
    int cyc = 0;
    int run_pops = 0;
    int first_pop = 0;
    int last_pop = 0;
    int viol_hold = 0;
    int viol_credit = 0;
    int viol_resp = 0;
    int viol_stall = 0;
    bit stall_chk = 0;
    logic [31:0] stall_data = '0;
    bit hold_pend = 0;
    logic [31:0] hold_addr = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model and request-side scoreboard
    initial begin
        bus.request_ready   = 1'b0;
        bus.read_data_valid = 1'b0;
        bus.read_data       = '0;
        out_ready           = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rest) begin
                pend.delete();
                bus.request_ready   = 1'b0;
                bus.read_data_valid = 1'b0;
                out_ready           = 1'b0;
                hold_pend           = 0;
                continue;
            end
            if (hold_pend && (!bus.read || bus.address !== hold_addr))
                viol_hold++;
            if (acc_total - pop_total > MAXO) viol_credit++;
            bus.request_ready = (rq_mode == 0) ? 1'b1
                              : ($urandom_range(0, 2) != 0);
            if (pend.size() != 0 && (dv_mode == 0 ||
                (dv_mode == 1 && $urandom_range(0, 1) == 1))) begin
                bus.read_data_valid = 1'b1;
                bus.read_data = {2'b00, pend[0][31:2]};
            end else begin
                bus.read_data_valid = 1'b0;
                bus.read_data = '0;
            end
            out_ready = (or_mode == 0) ? 1'b1
                      : (or_mode == 1) ? ($urandom_range(0, 1) == 1)
                      : 1'b0;
            if (bus.read_data_valid && !bus.resp_ready) viol_resp++;
            if (bus.read_data_valid && bus.resp_ready) begin
                void'(pend.pop_front());
                rsp_total++;
            end
            if (bus.read && bus.request_ready) begin
                if (exp_addr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_read: got read at %h required none",
                             bus.address);
                end else begin
                    check("rd_addr", bus.address, exp_addr.pop_front());
                end
                pend.push_back(bus.address);
                acc_total++;
                hold_pend = 0;
            end else begin
                hold_pend = bus.read;
                hold_addr = bus.address;
            end
        end
    end

    // Output monitor: pops expected words as the stream hands them over
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rest) continue;
            if (done) begin
                done_cnt++;
                check("busy_at_done", {31'd0, busy}, 32'd0);
                check("drained_at_done", exp_data.size(), 32'd0);
            end
            if (stall_chk && out_data !== stall_data) viol_stall++;
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_word: got %h required none", out_data);
                end else begin
                    check("out_data", out_data, exp_data.pop_front());
                end
                if (run_pops == 0) first_pop = cyc;
                last_pop = cyc;
                run_pops++;
                pop_total++;
            end
        end
    end

    task automatic do_start(input logic [31:0] base, input int wc);
        logic [31:0] a;
        a = base & 32'hFFFF_FFFC;
        for (int i = 0; i < wc; i++) begin
            exp_addr.push_back(a);
            exp_data.push_back({2'b00, a[31:2]});
            a = a + 32'd4;
        end
        @(negedge clk);
        #2;
        run_pops   = 0;
        done_base  = done_cnt;
        start      = 1'b1;
        base_addr  = base;
        word_count = wc[15:0];
        @(negedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != done_base) return;
            @(negedge clk);
            #2;
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: got no done in %0d cycles required one",
                 budget);
    endtask

    initial begin
        rest       = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_read", {31'd0, bus.read}, 32'd0);
        check("rst_addr", bus.address, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_resp_ready", {31'd0, bus.resp_ready}, 32'd1);
        check("const_byte_en", {28'd0, bus.byte_en}, 32'hF);
        check("const_write", {31'd0, bus.write}, 32'd0);
        check("const_burst", {24'd0, bus.burst_count}, 32'd1);
        rest = 1'b1;

        // 8 words at full rate: data 0x40..0x47
        rq_mode = 0; dv_mode = 0; or_mode = 0;
        do_start(32'h100, 8);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(100);
        repeat (4) @(negedge clk);
        #2;
        check("t1_done_pulses", done_cnt - done_base, 32'd1);
        check("t1_words", run_pops, 32'd8);
        check("t1_rate", last_pop - first_pop, 32'd7);

        // 1000 words, random slave and sink
        rq_mode = 1; dv_mode = 1; or_mode = 1;
        do_start(32'h2000, 1000);
        wait_done(20000);
        check("t2_words", run_pops, 32'd1000);
        check("t2_left", exp_data.size(), 32'd0);

        // sink stalled for 20 cycles mid-transfer
        rq_mode = 0; dv_mode = 0; or_mode = 0;
        do_start(32'h4000, 40);
        for (int i = 0; i < 200 && run_pops < 10; i++) begin
            @(negedge clk);
            #2;
        end
        or_mode = 2;
        start = 1'b1;
        base_addr = 32'h8000;
        word_count = 16'd5;
        @(negedge clk);
        #2;
        start = 1'b0;
        stall_data = out_data;
        stall_chk = 1;
        repeat (19) @(negedge clk);
        #2;
        check("t3_buffered", acc_total - pop_total, 32'd4);
        check("t3_read_off", {31'd0, bus.read}, 32'd0);
        check("t3_valid", {31'd0, out_valid}, 32'd1);
        stall_chk = 0;
        check("t3_stable", viol_stall, 32'd0);
        or_mode = 0;
        wait_done(200);
        check("t3_words", run_pops, 32'd40);

        // zero-length request
        do_start(32'h300, 0);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        #2;
        check("t4_done_pulses", done_cnt - done_base, 32'd1);

        // address wrap: 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000
        do_start(32'hFFFF_FFF9, 3);
        wait_done(100);
        check("t5_words", run_pops, 32'd3);

        // reset with reads outstanding
        dv_mode = 2;
        do_start(32'h600, 8);
        for (int i = 0; i < 50 && (acc_total - rsp_total) < 3; i++) begin
            @(negedge clk);
            #2;
        end
        rest = 1'b0;
        #1;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_read", {31'd0, bus.read}, 32'd0);
        check("t6_addr", bus.address, 32'd0);
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        exp_addr.delete();
        exp_data.delete();
        acc_total = 0;
        rsp_total = 0;
        pop_total = 0;
        @(negedge clk);
        #2;
        rest = 1'b1;
        dv_mode = 0;
        do_start(32'h700, 4);
        wait_done(100);
        check("t6_words", run_pops, 32'd4);

        check("hold_violations", viol_hold, 32'd0);
        check("credit_violations", viol_credit, 32'd0);
        check("resp_block", viol_resp, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avl_stream_reader.md
Name: avl_stream_reader

Overview:
- Avalon-style bus initiator that reads a linear region of word memory and presents it as a valid/ready stream.
- It drives the master side of i_avl_bus, the counterpart of the SDRAM slave and its simulation model. Typical use is frame-buffer readout toward the HDMI path.
- Single-word reads only. Keeps up to MAX_OUTSTANDING reads in flight, gated by credits against an internal response FIFO.

Parameters:
- MAX_OUTSTANDING, 4, maximum reads issued but not yet popped from the output; also the response FIFO depth; power of 2, at least 2.
- LEN_WIDTH, 16, width of word_count.

Ports:
- clk  input  1  clock; all logic on posedge.
- rest  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; latches base_addr/word_count when idle.
- base_addr  input  32  byte address of first word; bits [1:0] ignored (forced 0).
- word_count  input  LEN_WIDTH  number of 32-bit words to read.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the last word is popped from the stream.
- avl_m0  i_avl_bus.master  -  uses address, byte_en, read, write, write_data, begin_burst_transfer, burst_count, request_ready, read_data, read_data_valid, resp_ready.
- out_data  output  32  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.

Behaviour:
- Reset values: busy=0, done=0, avl_m0.read=0, avl_m0.address=0, out_valid=0, FIFO empty, all counters 0.
- Constant bus outputs: write=0, write_data=0, byte_en=4'hF, burst_count=1, begin_burst_transfer=0.
- Request accept: read && request_ready in the same cycle. Response accept: read_data_valid && resp_ready.
- Once read is asserted, read and address hold stable until accepted. read is never withdrawn.
- resp_ready is registered-free logic equal to !fifo_full. It must not depend combinationally on request_ready, because the slave's request_ready depends on resp_ready.
- Credit rule: read may be asserted only when both hold:
  - in_flight + fifo_count < MAX_OUTSTANDING;
  - issued < word_count.
  - in_flight is incremented on request accept and decremented on response accept.
  - Under this rule resp_ready is always 1 in practice; the bench checks it never blocks.
- Address: starts at {base_addr[31:2],2'b00} and advances by 4 on each request accept. Wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- Response FIFO:
  - Registered. Data accepted in cycle N is visible on out_data/out_valid at cycle N+1 at the earliest.
  - Simultaneous push and pop when full or empty is legal; count is unchanged.
  - out_data holds while out_valid && !out_ready.
- FSM:
  - IDLE: start -> RUN (busy=1, issued=0, popped=0). If word_count==0, go instead to FIN: no request is issued and done pulses the cycle after start.
  - RUN: issue reads per the credit rule. Once issued==word_count, stop issuing and keep draining. The cycle the pop of word word_count occurs -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
  - A new start is accepted in IDLE only; start in RUN/FIN is ignored.
- Throughput: 1 word/cycle sustained when request_ready, read_data_valid and out_ready are continuously high.
- Order: out_data order equals request order. The slave returns in order, so no reordering logic.
- Reset mid-operation: everything returns to reset values immediately. Outstanding slave responses are dropped; the slave is reset by the same rest.

Test Plan:
- Model with REQUEST_RANDOM=0, DATA_VALID_RANDOM=0, preloaded ram[i]=i; start, base_addr=0x100, word_count=8, out_ready=1 -> read addresses 0x100..0x11C. out_data 0x40..0x47 in order at one word/cycle after initial latency. A single done pulse; busy drops with it.
- Random request_ready/read_data_valid (model defaults); word_count=1000, out_ready random 50% -> all 1000 words correct and in order. in_flight+fifo_count never exceeds 4. read never deasserts before accept. resp_ready never low while read_data_valid high.
- out_ready=0 for 20 cycles mid-transfer -> exactly MAX_OUTSTANDING words buffered, then read stays 0. out_data stable while stalled. Resumes with no loss or duplication.
- word_count=0 -> no read asserted; done one cycle after start.
- base_addr=0xFFFFFFF9, word_count=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rest pulsed low with 3 reads outstanding -> all outputs at reset values asynchronously. A subsequent start with word_count=4 completes correctly.
